// File: rtl/imm_broadcast_sequencer_pkg.sv
// vec_pkg: shared immediate modes, sequencer states and default vector geometry
package vec_pkg;
    localparam int LANES_DEF      = 16;
    localparam int BEAT_LANES_DEF = 4;
    typedef enum logic [1:0] {BCAST, ZEXT8, SEXT8, RAMP} imm_mode_t;
    typedef enum logic {IDLE, ISSUE} seq_state_t;
endpackage

// File: rtl/imm_broadcast_sequencer_lane_gen.sv
// imm_lane_gen: combinational value of one vector lane from an immediate
// Ports: imm (16-bit immediate), mode (imm_mode_t), g (global lane index),
//        value (N-bit lane value before masking)
module imm_lane_gen
    import vec_pkg::*;
#(
    parameter int N  = 16,
    parameter int GW = 4
) (
    input  logic [15:0]   imm,
    input  imm_mode_t     mode,
    input  logic [GW-1:0] g,
    output logic [N-1:0]  value
);
    // Widened copies let any N either truncate or zero/sign-extend cleanly.
    logic [N+15:0]   imm_w;
    logic [N+7:0]    z8_w;
    logic [N+7:0]    s8_w;
    logic [N+GW-1:0] g_w;
    assign imm_w = {{N{1'b0}}, imm};
    assign z8_w  = {{N{1'b0}}, imm[7:0]};
    assign s8_w  = {{N{imm[7]}}, imm[7:0]};
    assign g_w   = {{N{1'b0}}, g};
    always_comb begin
        value = mode == BCAST ? imm_w[N-1:0] :
                mode == ZEXT8 ? z8_w[N-1:0]  :
                mode == SEXT8 ? s8_w[N-1:0]  :
                                imm_w[N-1:0] + g_w[N-1:0];
    end
endmodule

// File: rtl/imm_broadcast_sequencer.sv
// imm_broadcast_sequencer: expands one immediate request into a beat-serialised lane vector
// Ports: clk/rst (sync active-high); req_valid/req_ready/req_imm/req_mode/req_vlen request side;
//        out_valid/out_ready/out_lanes/out_mask/out_beat/out_last beat stream; busy = not IDLE
module imm_broadcast_sequencer
    import vec_pkg::*;
#(
    parameter int N          = 16,
    parameter int LANES      = LANES_DEF,
    parameter int BEAT_LANES = BEAT_LANES_DEF,
    localparam int NB        = LANES / BEAT_LANES,
    localparam int BW        = NB > 1 ? $clog2(NB) : 1,
    localparam int GW        = LANES > 1 ? $clog2(LANES) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [15:0]             req_imm,
    input  logic [1:0]              req_mode,
    input  logic [4:0]              req_vlen,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BEAT_LANES*N-1:0] out_lanes,
    output logic [BEAT_LANES-1:0]   out_mask,
    output logic [BW-1:0]           out_beat,
    output logic                    out_last,
    output logic                    busy
);
    seq_state_t    state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [15:0]   imm_q, imm_d;
    imm_mode_t     mode_q, mode_d;
    logic [4:0]    vlen_q, vlen_d;
    logic [4:0]    vlen_clamped;
    logic [31:0]   base;
    logic          active;
    logic          last_w;
    assign vlen_clamped = req_vlen > 5'(LANES) ? 5'(LANES) : req_vlen;
    assign active       = state_q == ISSUE;
    assign base         = 32'(beat_q) * 32'(BEAT_LANES);
    // A beat is final once it covers lane vlen-1, i.e. beat == ceil(vlen/BEAT_LANES)-1.
    assign last_w       = base + 32'(BEAT_LANES) >= 32'(vlen_q);
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            imm_q   <= '0;
            mode_q  <= BCAST;
            vlen_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            imm_q   <= imm_d;
            mode_q  <= mode_d;
            vlen_q  <= vlen_d;
        end
    end
    // Capture registers only load in IDLE, so req_* activity during ISSUE is ignored.
    // A zero-length request is consumed but leaves the FSM in IDLE.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        imm_d   = imm_q;
        mode_d  = mode_q;
        vlen_d  = vlen_q;
        if (!active && req_valid) begin
            imm_d   = req_imm;
            mode_d  = imm_mode_t'(req_mode);
            vlen_d  = vlen_clamped;
            beat_d  = '0;
            state_d = vlen_clamped != 5'd0 ? ISSUE : IDLE;
        end else if (active && out_ready) begin
            beat_d  = last_w ? '0 : beat_q + 1'b1;
            state_d = last_w ? IDLE : ISSUE;
        end
    end
    assign req_ready = !active;
    assign busy      = active;
    assign out_valid = active;
    assign out_beat  = beat_q;
    assign out_last  = active && last_w;
    for (genvar k = 0; k < BEAT_LANES; k++) begin : g_lane
        logic [31:0] idx;
        logic [N-1:0] value;
        assign idx = base + 32'(k);
        imm_lane_gen #(.N(N), .GW(GW)) u_gen (
            .imm  (imm_q),
            .mode (mode_q),
            .g    (idx[GW-1:0]),
            .value(value)
        );
        assign out_mask[k]        = active && idx < 32'(vlen_q);
        assign out_lanes[k*N +: N] = out_mask[k] ? value : '0;
    end
endmodule

// File: tb/tb_imm_broadcast_sequencer.sv
// tb_imm_broadcast_sequencer: directed table, stall/reset sequences and random requests against a lane model
module tb_imm_broadcast_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_imm = '0;
    logic [1:0]  req_mode = '0;
    logic [4:0]  req_vlen = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_lanes;
    logic [3:0]  out_mask;
    logic [1:0]  out_beat;
    logic        out_last;
    logic        busy;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    imm_broadcast_sequencer dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_imm(req_imm), .req_mode(req_mode), .req_vlen(req_vlen),
        .out_valid(out_valid), .out_ready(out_ready), .out_lanes(out_lanes),
        .out_mask(out_mask), .out_beat(out_beat), .out_last(out_last), .busy(busy)
    );
    typedef struct {
        logic [15:0] imm;
        logic [1:0]  mode;
        logic [4:0]  vlen;
        int          nbeats;
        logic [63:0] first_lanes;
        logic [3:0]  last_mask;
    } vec_t;
    vec_t tbl[6];
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    // Lane value straight from the mode rules; lanes at or beyond vlen read 0.
    function automatic logic [15:0] ref_lane(input logic [15:0] imm, input logic [1:0] mode,
                                             input int g, input int vlen);
        if (g >= vlen) return 16'h0;
        case (mode)
            2'd0: return imm;
            2'd1: return {8'h00, imm[7:0]};
            2'd2: return {{8{imm[7]}}, imm[7:0]};
            default: return imm + 16'(g);
        endcase
    endfunction
    function automatic logic [63:0] ref_beat(input logic [15:0] imm, input logic [1:0] mode,
                                             input int b, input int vlen);
        logic [63:0] r = '0;
        for (int k = 0; k < 4; k++) r[k*16 +: 16] = ref_lane(imm, mode, b*4 + k, vlen);
        return r;
    endfunction
    function automatic logic [3:0] ref_mask(input int b, input int vlen);
        logic [3:0] m = '0;
        for (int k = 0; k < 4; k++) m[k] = (b*4 + k) < vlen;
        return m;
    endfunction
    task automatic check_idle(input string tag);
        check({tag, ".valid"}, 64'(out_valid), 64'd0);
        check({tag, ".ready"}, 64'(req_ready), 64'd1);
        check({tag, ".busy"},  64'(busy),      64'd0);
    endtask
    // Issues one request at a negedge and follows it to completion, checking every
    // visible beat (including stalled repeats) against the model.
    task automatic do_req(input logic [15:0] imm, input logic [1:0] mode, input logic [4:0] vlen,
                          input int stall_pct, output int nbeats,
                          output logic [63:0] first_lanes, output logic [3:0] last_mask);
        int ve = vlen > 16 ? 16 : int'(vlen);
        int nb_exp = (ve + 3) / 4;
        int b = 0;
        int cyc = 0;
        bit r;
        nbeats = 0; first_lanes = '0; last_mask = '0;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        check("req_ready_wait", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_imm = imm; req_mode = mode; req_vlen = vlen;
        @(negedge clk);
        req_valid = 1'b0;
        if (nb_exp == 0) begin
            check_idle("drop");
            return;
        end
        forever begin
            req_valid = 1'($urandom); req_imm = 16'($urandom); req_mode = 2'($urandom); req_vlen = 5'($urandom);
            check("valid", 64'(out_valid), 64'd1);
            check("beat",  64'(out_beat),  64'(b));
            check("lanes", out_lanes,      ref_beat(imm, mode, b, ve));
            check("mask",  64'(out_mask),  64'(ref_mask(b, ve)));
            check("last",  64'(out_last),  64'(b == nb_exp - 1));
            if (b == 0) first_lanes = out_lanes;
            r = $urandom_range(99) >= stall_pct;
            out_ready = r;
            @(negedge clk);
            cyc++;
            if (r) begin
                nbeats++;
                if (b == nb_exp - 1) begin
                    last_mask = ref_mask(b, ve);
                    req_valid = 1'b0; out_ready = 1'b0;
                    check_idle("after_last");
                    return;
                end
                b++;
            end
            if (cyc > 400) begin
                check("cycle_budget", 64'(cyc), 64'd400);
                req_valid = 1'b0; out_ready = 1'b0;
                return;
            end
        end
    endtask
    initial begin
        int nb;
        logic [63:0] fl;
        logic [3:0] lm;
        tbl[0] = '{16'h1234, 2'd0, 5'd16, 4, {4{16'h1234}}, 4'hF};
        tbl[1] = '{16'hFFFE, 2'd3, 5'd6,  2, 64'h0001_0000_FFFF_FFFE, 4'h3};
        tbl[2] = '{16'h0080, 2'd2, 5'd4,  1, {4{16'hFF80}}, 4'hF};
        tbl[3] = '{16'hAB12, 2'd1, 5'd0,  0, 64'h0, 4'h0};
        tbl[4] = '{16'hAB12, 2'd1, 5'd20, 4, {4{16'h0012}}, 4'hF};
        tbl[5] = '{16'h8001, 2'd0, 5'd1,  1, 64'h0000_0000_0000_8001, 4'h1};
        repeat (2) @(negedge clk);
        check_idle("reset");
        check("reset.lanes", out_lanes, 64'h0);
        check("reset.mask",  64'(out_mask), 64'h0);
        check("reset.beat",  64'(out_beat), 64'h0);
        check("reset.last",  64'(out_last), 64'h0);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            do_req(tbl[i].imm, tbl[i].mode, tbl[i].vlen, 0, nb, fl, lm);
            check($sformatf("tbl%0d.nbeats", i), 64'(nb), 64'(tbl[i].nbeats));
            check($sformatf("tbl%0d.first", i),  fl,      tbl[i].first_lanes);
            check($sformatf("tbl%0d.lmask", i),  64'(lm), 64'(tbl[i].last_mask));
        end
        // Stall a single SEXT8 beat for three cycles, then release it.
        req_valid = 1'b1; req_imm = 16'h0080; req_mode = 2'd2; req_vlen = 5'd4; out_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall.valid", 64'(out_valid), 64'd1);
            check("stall.lanes", out_lanes, {4{16'hFF80}});
            check("stall.last",  64'(out_last), 64'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_idle("stall.done");
        // Reset while beat 1 of a full vector is on the bus.
        req_valid = 1'b1; req_imm = 16'h5555; req_mode = 2'd0; req_vlen = 5'd16; out_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("rst.beat0", 64'(out_beat), 64'd0);
        @(negedge clk);
        check("rst.beat1", 64'(out_beat), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b0;
        check_idle("rst.abort");
        check("rst.beat", 64'(out_beat), 64'd0);
        check("rst.mask", 64'(out_mask), 64'd0);
        do_req(16'h0102, 2'd3, 5'd16, 0, nb, fl, lm);
        check("rst.restart", 64'(nb), 64'd4);
        for (int i = 0; i < 60; i++)
            do_req(16'($urandom), 2'($urandom), 5'($urandom), 30, nb, fl, lm);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/imm_broadcast_sequencer.md
IMM_BROADCAST_SEQUENCER -- requirements
Module: imm_broadcast_sequencer

Interface
REQ-001 SHALL have parameter N, default 16, lane width in bits.
REQ-002 SHALL have parameter LANES, default 16, total vector lanes.
REQ-003 SHALL have parameter BEAT_LANES, default 4, lanes emitted per output beat; LANES SHALL be a multiple of BEAT_LANES.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  sequencer can accept a request.
REQ-008 req_imm  input  16  immediate operand.
REQ-009 req_mode  input  2  0 BCAST, 1 ZEXT8, 2 SEXT8, 3 RAMP.
REQ-010 req_vlen  input  5  active lane count, 0..16.
REQ-011 out_valid  output  1  beat present.
REQ-012 out_ready  input  1  downstream accepts beat.
REQ-013 out_lanes  output  BEAT_LANES x N  packed lane values, element 0 = lowest lane of beat.
REQ-014 out_mask  output  BEAT_LANES  per-lane active flag.
REQ-015 out_beat  output  2  beat index within vector (log2(LANES/BEAT_LANES) bits).
REQ-016 out_last  output  1  current beat is final beat of request.
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 SHALL implement FSM states IDLE and ISSUE only.
REQ-019 req_ready SHALL equal (state == IDLE); a request is accepted on a cycle with req_valid && req_ready.
REQ-020 On acceptance with req_vlen 1..16, SHALL capture imm, mode, vlen, set beat counter 0 and enter ISSUE; out_valid high the following cycle (latency 1).
REQ-021 req_vlen values 17..31 SHALL be clamped to 16.
REQ-022 Acceptance with req_vlen == 0 SHALL be consumed and dropped: state stays IDLE, no beat issued.
REQ-023 Number of beats SHALL be ceil(vlen / BEAT_LANES); out_last high on beat index beats-1.
REQ-024 Global lane index g = out_beat*BEAT_LANES + k; out_mask[k] SHALL be 1 iff g < vlen.
REQ-025 Active lane value: BCAST imm[N-1:0] (zero-extended if N > 16); ZEXT8 zero-extended imm[7:0]; SEXT8 sign-extended imm[7:0]; RAMP (imm + g) modulo 2^N.
REQ-026 Masked-off lanes SHALL drive 0.
REQ-027 out_valid, out_lanes, out_mask, out_beat, out_last SHALL remain stable while out_valid && !out_ready.
REQ-028 On out_valid && out_ready and not last, beat counter SHALL increment; next beat valid next cycle with no bubble.
REQ-029 On out_valid && out_ready && out_last, SHALL return to IDLE; req_ready high next cycle; no request accepted in the same cycle as last handshake.
REQ-030 Capture registers SHALL not change while in ISSUE regardless of req_* inputs.

Reset
REQ-031 rst SHALL force IDLE, beat counter 0, out_valid 0, out_last 0, out_mask 0, out_lanes 0, out_beat 0, busy 0, req_ready 1 on the next edge.
REQ-032 rst during ISSUE SHALL abort the vector with no further beats; rst dominates any simultaneous handshake.

Structure
REQ-033 Package vec_pkg SHALL hold the imm_mode_t enum (BCAST, ZEXT8, SEXT8, RAMP) and LANES/BEAT_LANES default constants.
REQ-034 Lane value computation SHALL be a combinational sub-module imm_lane_gen (inputs imm, mode, global lane index; output N-bit value), instantiated BEAT_LANES times.

Verification
REQ-035 BCAST imm=0x1234, vlen=16, out_ready=1 -> 4 consecutive beats, all lanes 0x1234, mask 0xF, out_last on beat 3, req_ready high the cycle after.
REQ-036 RAMP imm=0xFFFE, vlen=6 -> beat0 lanes FFFE,FFFF,0000,0001 mask F; beat1 lanes 0002,0003,0,0 mask 0x3 with out_last.
REQ-037 SEXT8 imm=0x0080, vlen=4, out_ready low 3 cycles -> single beat 0xFF80 x4 held stable for 3 cycles, completes on ready.
REQ-038 vlen=0 request then vlen=20 ZEXT8 imm=0xAB12 -> first dropped with no beat; second issues 4 beats of 0x0012, mask 0xF.
REQ-039 rst asserted during beat 1 of vlen=16 -> next cycle out_valid 0, req_ready 1, busy 0; new request then starts at beat 0.
